// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the selecting / round-robin pipeline mux.
//   MODE_SEL  - output channel chosen by the explicit sel input
//   MODE_RR   - output channel chosen by a round-robin search over in_valid
//   sel_width - width of a channel index for a given channel count (min 1)
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int sel_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin channel search with a rotating start pointer.
//   clk, rst_n - clock, asynchronous active-low reset (ptr -> 0)
//   req        - per-channel request (in_valid)
//   adv        - a transfer happened on grant this cycle; ptr moves past it
//   grant      - index of the first requesting channel at or after ptr
//   grant_vld  - some channel is requesting
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int SW  = sel_width(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [SW-1:0]  grant,
    output logic           grant_vld
);

    logic [SW-1:0] ptr;

    // Each channel's distance from ptr going upward with wrap; the closest
    // requester wins. Avoids variable-index part selects on req.
    always_comb begin
        int unsigned p;
        int unsigned d;
        int unsigned best;
        p         = {{(32-SW){1'b0}}, ptr};
        d         = 0;
        best      = NCH;
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            d = (i >= p) ? (i - p) : (i + NCH - p);
            if (req[i] && d < best) begin
                best      = d;
                grant     = SW'(i);
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (grant == SW'(NCH - 1)) ? '0 : grant + SW'(1);
        end
    end

endmodule

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: N-channel valid/ready mux with a single registered output stage.
//   clk, rst_n - clock, asynchronous active-low reset
//   in_data    - NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel accept; at most one bit set
//   sel        - channel select (MODE_SEL only)
//   out_data   - registered data of the last accepted word
//   out_valid  - out_data holds an unconsumed word
//   out_ready  - downstream accept
//   out_ch     - channel that supplied out_data
module sel_mux_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SW    = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_ch
);

    logic             load;
    logic             xfer;
    logic [SW-1:0]    grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;

    assign load = !out_valid || out_ready;
    assign xfer = |(in_valid & in_ready);

    generate
        if (NCH == 1) begin : g_single
            logic unused_sel;
            assign unused_sel = ^sel;
            assign grant      = '0;
            assign grant_vld  = 1'b1;
        end else if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;
            rr_arbiter #(
                .NCH (NCH)
            ) u_arb (
                .clk       (clk),
                .rst_n     (rst_n),
                .req       (in_valid),
                .adv       (xfer),
                .grant     (grant),
                .grant_vld (grant_vld)
            );
        end else begin : g_sel
            assign grant     = sel;
            assign grant_vld = ({{(32-SW){1'b0}}, sel} < NCH);
        end
    endgenerate

    // in_ready is held low during reset so no handshake can complete while
    // the output stage is being cleared.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant == SW'(i)) begin
                in_ready[i] = rst_n && load && grant_vld;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sel_mux_pipe.sv
module tb_sel_mux_pipe;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // MODE_SEL, NCH=4
    logic [127:0] d4s;
    logic [3:0]   v4s, r4s;
    logic [1:0]   s4s, och4s;
    logic [31:0]  od4s;
    logic         ov4s, ordy4s;
    // MODE_RR, NCH=4
    logic [127:0] d4r;
    logic [3:0]   v4r, r4r;
    logic [1:0]   s4r, och4r;
    logic [31:0]  od4r;
    logic         ov4r, ordy4r;
    // MODE_SEL, NCH=5
    logic [159:0] d5;
    logic [4:0]   v5, r5;
    logic [2:0]   s5, och5;
    logic [31:0]  od5;
    logic         ov5, ordy5;

    sel_mux_pipe #(.WIDTH(32), .NCH(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4s), .in_valid(v4s), .in_ready(r4s),
        .sel(s4s), .out_data(od4s), .out_valid(ov4s), .out_ready(ordy4s), .out_ch(och4s));

    sel_mux_pipe #(.WIDTH(32), .NCH(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4r), .in_valid(v4r), .in_ready(r4r),
        .sel(s4r), .out_data(od4r), .out_valid(ov4r), .out_ready(ordy4r), .out_ch(och4r));

    sel_mux_pipe #(.WIDTH(32), .NCH(5), .MODE(MODE_SEL)) u_sel5 (
        .clk(clk), .rst_n(rst_n), .in_data(d5), .in_valid(v5), .in_ready(r5),
        .sel(s5), .out_data(od5), .out_valid(ov5), .out_ready(ordy5), .out_ch(och5));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (ov4s !== 1'b0) begin fails++; $display("FAIL reset_ov_sel4 got=%0b exp=0", ov4s); end
        tests++; if (od4s !== 32'h0) begin fails++; $display("FAIL reset_od_sel4 got=%h exp=0", od4s); end
        tests++; if (och4s !== 2'd0) begin fails++; $display("FAIL reset_och_sel4 got=%0d exp=0", och4s); end
        tests++; if (r4s !== 4'b0000) begin fails++; $display("FAIL reset_rdy_sel4 got=%b exp=0000", r4s); end
        tests++; if (ov4r !== 1'b0) begin fails++; $display("FAIL reset_ov_rr4 got=%0b exp=0", ov4r); end
        tests++; if (ov5 !== 1'b0) begin fails++; $display("FAIL reset_ov_sel5 got=%0b exp=0", ov5); end
    endtask

    task automatic test_sel_basic;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        s4s    = 2'd2;
        v4s    = 4'b0100;
        ordy4s = 1'b1;
        #1;
        tests++; if (r4s !== 4'b0100) begin fails++; $display("FAIL sel_basic_rdy got=%b exp=0100", r4s); end
        tick();
        tests++; if (ov4s !== 1'b1) begin fails++; $display("FAIL sel_basic_ov got=%0b exp=1", ov4s); end
        tests++; if (od4s !== 32'hA5A5_0002) begin fails++; $display("FAIL sel_basic_od got=%h exp=a5a50002", od4s); end
        tests++; if (och4s !== 2'd2) begin fails++; $display("FAIL sel_basic_och got=%0d exp=2", och4s); end
    endtask

    task automatic test_stall;
        ordy4s = 1'b0;
        v4s    = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            s4s = (c == 0) ? 2'd2 : 2'd1;
            #1;
            tests++; if (r4s !== 4'b0000) begin fails++; $display("FAIL stall_rdy c=%0d got=%b exp=0000", c, r4s); end
            tick();
            tests++; if (od4s !== 32'hA5A5_0002 || och4s !== 2'd2 || ov4s !== 1'b1)
                begin fails++; $display("FAIL stall_hold c=%0d got=%h/%0d/%0b exp=a5a50002/2/1", c, od4s, och4s, ov4s); end
        end
        ordy4s = 1'b1;
        #1;
        tests++; if (r4s !== 4'b0010) begin fails++; $display("FAIL stall_release_rdy got=%b exp=0010", r4s); end
        tick();
        tests++; if (od4s !== 32'hA5A5_0001 || och4s !== 2'd1)
            begin fails++; $display("FAIL stall_release_out got=%h/%0d exp=a5a50001/1", od4s, och4s); end
        v4s = 4'b0000;
        tick();
        tests++; if (ov4s !== 1'b0) begin fails++; $display("FAIL drain_ov got=%0b exp=0", ov4s); end
        tests++; if (od4s !== 32'hA5A5_0001 || och4s !== 2'd1)
            begin fails++; $display("FAIL drain_hold got=%h/%0d exp=a5a50001/1", od4s, och4s); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] seq [3];
        seq[0] = 2'd0; seq[1] = 2'd3; seq[2] = 2'd1;
        v4s    = 4'b1111;
        ordy4s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s4s = seq[k];
            tick();
            tests++; if (ov4s !== 1'b1 || och4s !== seq[k] || od4s !== (32'hA5A5_0000 + 32'(seq[k])))
                begin fails++; $display("FAIL b2b k=%0d got=%0b/%0d/%h exp=1/%0d", k, ov4s, och4s, od4s, seq[k]); end
        end
        v4s = 4'b0000;
    endtask

    task automatic test_rr_sequence;
        logic [1:0] exp5 [5];
        logic [1:0] exp3 [3];
        exp5[0] = 2'd0; exp5[1] = 2'd1; exp5[2] = 2'd2; exp5[3] = 2'd3; exp5[4] = 2'd0;
        exp3[0] = 2'd3; exp3[1] = 2'd0; exp3[2] = 2'd3;
        ordy4r = 1'b1;
        v4r    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if (ov4r !== 1'b1 || och4r !== exp5[k] || od4r !== (32'h1000_0000 + 32'(exp5[k])))
                begin fails++; $display("FAIL rr_all k=%0d got=%0b/%0d/%h exp=1/%0d", k, ov4r, och4r, od4r, exp5[k]); end
        end
        // ptr is now 1
        v4r = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (och4r !== exp3[k])
                begin fails++; $display("FAIL rr_1001 k=%0d got=%0d exp=%0d", k, och4r, exp3[k]); end
        end
    endtask

    task automatic test_reset_mid;
        v4r = 4'b0010;
        tick();
        tests++; if (och4r !== 2'd1) begin fails++; $display("FAIL rrmid_pre got=%0d exp=1", och4r); end
        ordy4r = 1'b0;
        v4r    = 4'b1111;
        tick();
        tests++; if (ov4r !== 1'b1 || och4r !== 2'd1)
            begin fails++; $display("FAIL rrmid_held got=%0b/%0d exp=1/1", ov4r, och4r); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (ov4r !== 1'b0 || od4r !== 32'h0 || och4r !== 2'd0)
            begin fails++; $display("FAIL rrmid_async got=%0b/%h/%0d exp=0/0/0", ov4r, od4r, och4r); end
        tests++; if (r4r !== 4'b0000) begin fails++; $display("FAIL rrmid_rdy_in_reset got=%b exp=0000", r4r); end
        tick();
        rst_n  = 1'b1;
        ordy4r = 1'b1;
        #1;
        tests++; if (r4r !== 4'b0001) begin fails++; $display("FAIL rrmid_first_grant got=%b exp=0001", r4r); end
        tick();
        tests++; if (ov4r !== 1'b1 || och4r !== 2'd0 || od4r !== 32'h1000_0000)
            begin fails++; $display("FAIL rrmid_first_out got=%0b/%0d/%h exp=1/0/10000000", ov4r, och4r, od4r); end
        v4r = 4'b0000;
    endtask

    task automatic test_sel_range;
        ordy5 = 1'b1;
        s5    = 3'd4;
        v5    = 5'b10000;
        #1;
        tests++; if (r5 !== 5'b10000) begin fails++; $display("FAIL sel5_ch4_rdy got=%b exp=10000", r5); end
        tick();
        tests++; if (ov5 !== 1'b1 || och5 !== 3'd4 || od5 !== 32'h5555_0004)
            begin fails++; $display("FAIL sel5_ch4_out got=%0b/%0d/%h exp=1/4/55550004", ov5, och5, od5); end
        s5 = 3'd5;
        v5 = 5'b11111;
        #1;
        tests++; if (r5 !== 5'b00000) begin fails++; $display("FAIL sel5_oob_rdy got=%b exp=00000", r5); end
        tick();
        tests++; if (ov5 !== 1'b0) begin fails++; $display("FAIL sel5_oob_drain got=%0b exp=0", ov5); end
        tests++; if (od5 !== 32'h5555_0004 || och5 !== 3'd4)
            begin fails++; $display("FAIL sel5_oob_hold got=%h/%0d exp=55550004/4", od5, och5); end
        s5 = 3'd7;
        #1;
        tests++; if (r5 !== 5'b00000) begin fails++; $display("FAIL sel5_sel7_rdy got=%b exp=00000", r5); end
        tick();
        tests++; if (ov5 !== 1'b0) begin fails++; $display("FAIL sel5_sel7_ov got=%0b exp=0", ov5); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            d4s[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
            d4r[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        end
        for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'h5555_0000 + 32'(i);
        v4s = 4'b1111; s4s = 2'd0; ordy4s = 1'b1;
        v4r = 4'b0000; s4r = 2'd0; ordy4r = 1'b1;
        v5  = 5'b0;    s5  = 3'd0; ordy5  = 1'b1;

        test_reset();
        test_sel_basic();
        test_stall();
        test_back_to_back();
        test_rr_sequence();
        test_reset_mid();
        test_sel_range();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sel_mux_pipe.md
SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per channel.
REQ-002 SHALL have parameter NCH, default 4: number of input channels, legal range 1..16.
REQ-003 SHALL have parameter MODE, default MODE_SEL: MODE_SEL = 0 (explicit select), MODE_RR = 1 (round-robin).
REQ-004 SHALL define SW = max(1, clog2(NCH)) as the select/channel-index width.
REQ-005 SHALL provide port: clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL provide port: rst_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL provide port: in_data  in  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL provide port: in_valid  in  NCH  per-channel data valid.
REQ-009 SHALL provide port: in_ready  out  NCH  per-channel accept.
REQ-010 SHALL provide port: sel  in  SW  channel select, used only in MODE_SEL.
REQ-011 SHALL provide port: out_data  out  WIDTH  registered selected data.
REQ-012 SHALL provide port: out_valid  out  1  out_data holds an unconsumed word.
REQ-013 SHALL provide port: out_ready  in  1  downstream accept.
REQ-014 SHALL provide port: out_ch  out  SW  index of the channel that supplied out_data.

Function
REQ-015 SHALL compute load = (!out_valid || out_ready); a transfer occurs on channel g when in_valid[g] && in_ready[g].
REQ-016 SHALL drive in_ready[i] = load && (grant == i); all other in_ready bits 0; at most one bit high per cycle.
REQ-017 SHALL, in MODE_SEL, set grant = sel; sel >= NCH grants no channel (in_ready all 0).
REQ-018 SHALL, in MODE_RR, grant the first valid channel at or after ptr, searching upward with wrap from NCH-1 to 0; no valid channel means no grant.
REQ-019 SHALL, in MODE_RR, update ptr to (g+1) mod NCH only on a transfer; ptr holds otherwise.
REQ-020 SHALL, on a transfer, register out_data <= in_data[g], out_ch <= g, out_valid <= 1 the next cycle (latency 1).
REQ-021 SHALL, when load is high and no transfer occurs, clear out_valid; out_data and out_ch hold.
REQ-022 SHALL hold out_data, out_ch and out_valid stable while out_valid && !out_ready, regardless of sel or in_valid changes.
REQ-023 SHALL sustain one transfer per cycle when out_ready stays high (simultaneous consume and load).
REQ-024 SHALL be purely combinational from in_valid/sel/out_ready to in_ready; no path from out_ready to out_data within the same cycle.
REQ-025 SHALL, for NCH = 1, always grant channel 0, with out_ch tied to 0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear out_valid, out_data, out_ch and ptr to 0, with in_ready forced to 0.
REQ-027 SHALL discard a word held mid-handshake when reset asserts; the first grant after release in MODE_RR goes to channel 0 if valid.

Structure
REQ-028 SHALL take MODE_SEL, MODE_RR and the SW width function from shared package mux_pkg.
REQ-029 SHALL place the round-robin search and ptr in sub-module rr_arbiter (inputs req, adv; output grant index and grant_vld), instantiated only for MODE_RR.

Verification
REQ-030 SHALL cover MODE_SEL, NCH=4: sel=2, in_valid=4'b0100, data2=32'hA5A5_0002, out_ready=1 -> out_data=32'hA5A5_0002 and out_ch=2 one cycle later.
REQ-031 SHALL cover stall: out_valid=1, out_ready=0 for 3 cycles while sel changes 2->1 -> out_data unchanged, in_ready=0.
REQ-032 SHALL cover MODE_RR, all four channels valid, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover MODE_RR with in_valid=4'b1001 and ptr=1 -> grant 3, then 0, then 3.
REQ-034 SHALL cover rst_n asserted mid-stream -> outputs 0 immediately (asynchronously); after release, first grant goes to channel 0.
REQ-035 SHALL cover MODE_SEL with sel=3'd5 at NCH=5 -> no grant, in_ready=0, out_valid falls after drain.
